fetch_unit: RTL

- Instruction-fetch stage of the RV32I core. Sits directly upstream of Decode_Module.
- Owns the PC register and issues one instruction-memory read at a time through a req/gnt/rvalid handshake.
- Presents the fetched word (Inst) plus its PC to decode with a valid/ready handshake.
- Takes the PCsrc value produced by decode/pc_control and computes the next PC when the current instruction is consumed.

---
 rtl/fetch_pkg.sv | 36 +++
 rtl/pc_next_mux.sv | 38 +++
 rtl/fetch_unit.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Types and constants shared by the instruction-fetch stage and the blocks
//   that talk to it (pc_control drives a pcsrc_e-encoded PCsrc).
//
//   pcsrc_e        : next-PC select encoding (2'b11 behaves as PC_PLUS4)
//   fetch_state_e  : fetch FSM state encoding
//   NOP_INST       : addi x0,x0,0, shown to decode while nothing was fetched
//   INST_BYTES     : byte stride between sequential instructions
//   is_misaligned  : true when an instruction address is not word aligned
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JALR   = 2'b10
    } pcsrc_e;

    typedef enum logic [2:0] {
        S_REQ   = 3'd0,
        S_WAIT  = 3'd1,
        S_HOLD  = 3'd2,
        S_NEXT  = 3'd3,
        S_FAULT = 3'd4
    } fetch_state_e;

    localparam logic [31:0] NOP_INST   = 32'h0000_0013;
    localparam logic [31:0] INST_BYTES = 32'd4;

    // RV32I without the C extension requires 4-byte aligned fetch addresses.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// -----------------------------------------------------------------------------
// pc_next_mux
//   Purely combinational next-PC selection for the instruction being consumed.
//
//   Ports:
//     pc_q          in  32  address of the instruction being consumed
//     pc_src        in   2  next-PC select (pcsrc_e, 2'b11 treated as PC+4)
//     branch_target in  32  PC+ImmExt from execute
//     jalr_target   in  32  rs1+ImmExt from execute (bit 0 cleared here)
//     next_pc       out 32  selected next program counter
//     misaligned    out  1  next_pc is not word aligned
// -----------------------------------------------------------------------------
module pc_next_mux
    import fetch_pkg::*;
(
    input  logic [31:0] pc_q,
    input  logic [1:0]  pc_src,
    input  logic [31:0] branch_target,
    input  logic [31:0] jalr_target,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    // Select the next PC and flag a misaligned result.
    always_comb begin
        next_pc = pc_q + INST_BYTES;
        case (pc_src)
            PC_PLUS4:  next_pc = pc_q + INST_BYTES;
            PC_BRANCH: next_pc = branch_target;
            // JALR clears the LSB of the computed target; bit 1 is kept so a
            // target like rs1+imm = ...2 still raises the misaligned flag.
            PC_JALR:   next_pc = jalr_target & 32'hFFFF_FFFE;
            default:   next_pc = pc_q + INST_BYTES;
        endcase
        misaligned = is_misaligned(next_pc);
    end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage of the RV32I core. Owns the PC, issues one
//   instruction-memory read at a time (req/gnt/rvalid) and hands the fetched
//   word plus its PC to decode over a valid/ready handshake. The next PC is
//   chosen from PCsrc at the moment decode consumes the instruction.
//
//   Ports:
//     clk           in   1  core clock, rising edge
//     rst           in   1  asynchronous reset, active low
//     PCsrc         in   2  next-PC select for the consumed instruction
//     BranchTarget  in  32  PC+ImmExt from execute
//     JalrTarget    in  32  rs1+ImmExt from execute
//     imem_req      out  1  read request (registered)
//     imem_addr     out 32  request address (registered)
//     imem_gnt      in   1  memory accepted the request
//     imem_rvalid   in   1  read data valid
//     imem_rdata    in  32  instruction word
//     Inst          out 32  instruction to decode
//     PC            out 32  address of Inst
//     PCPlus4       out 32  PC+4, registered alongside PC
//     inst_valid    out  1  Inst/PC valid
//     inst_ready    in   1  decode consumes Inst this cycle
//     fetch_fault   out  1  sticky misaligned-target flag
//
//   Sequence per instruction: S_REQ -> S_WAIT -> S_HOLD -> S_NEXT -> S_REQ.
//   S_NEXT is a deliberate bubble so imem_addr is always a register output
//   and PCsrc never reaches the memory address combinationally.
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  PCsrc,
    input  logic [31:0] BranchTarget,
    input  logic [31:0] JalrTarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Inst,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic        fetch_fault
);

    fetch_state_e state_q, state_d;

    logic [31:0] pc_q,          pc_d;
    logic [31:0] pc_plus4_q,    pc_plus4_d;
    logic [31:0] inst_q,        inst_d;
    logic        inst_valid_q,  inst_valid_d;
    logic        imem_req_q,    imem_req_d;
    logic [31:0] imem_addr_q,   imem_addr_d;
    logic        fetch_fault_q, fetch_fault_d;
    logic        outstanding_q, outstanding_d;

    logic [31:0] next_pc_s;
    logic        misaligned_s;
    logic        grant_s;
    logic        resp_s;
    logic        accept_s;

    pc_next_mux u_pc_next_mux (
        .pc_q          (pc_q),
        .pc_src        (PCsrc),
        .branch_target (BranchTarget),
        .jalr_target   (JalrTarget),
        .next_pc       (next_pc_s),
        .misaligned    (misaligned_s)
    );

    // Handshake qualifiers. A response only counts while a read is in
    // flight, which drops stale data from a request abandoned by reset.
    always_comb begin
        grant_s  = imem_req_q & imem_gnt;
        resp_s   = imem_rvalid & outstanding_q;
        accept_s = inst_valid_q & inst_ready;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ: begin
                if (grant_s) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (resp_s) begin
                    state_d = S_HOLD;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_HOLD: begin
                if (accept_s) begin
                    if (misaligned_s) begin
                        state_d = S_FAULT;
                    end else begin
                        state_d = S_NEXT;
                    end
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_NEXT:  state_d = S_REQ;
            S_FAULT: state_d = S_FAULT;
            // An unreachable encoding is treated as a fault so the core stops
            // fetching rather than running from an unknown PC.
            default: state_d = S_FAULT;
        endcase
    end

    // FSM output / datapath next values. Outputs are decoded from state_d so
    // that every port below comes straight from a flop.
    always_comb begin
        pc_d          = pc_q;
        pc_plus4_d    = pc_plus4_q;
        inst_d        = inst_q;
        outstanding_d = outstanding_q;
        imem_addr_d   = imem_addr_q;

        // PC and PCPlus4 advance together when decode takes the instruction;
        // a misaligned target is still latched so the offending address is
        // visible on PC while faulted.
        if ((state_q == S_HOLD) && accept_s) begin
            pc_d       = next_pc_s;
            pc_plus4_d = next_pc_s + INST_BYTES;
        end else begin
            pc_d       = pc_q;
            pc_plus4_d = pc_plus4_q;
        end

        if ((state_q == S_REQ) && grant_s) begin
            outstanding_d = 1'b1;
        end else if (resp_s) begin
            outstanding_d = 1'b0;
        end else begin
            outstanding_d = outstanding_q;
        end

        if ((state_q == S_WAIT) && resp_s) begin
            inst_d = imem_rdata;
        end else begin
            inst_d = inst_q;
        end

        if (state_d == S_REQ) begin
            imem_addr_d = pc_d;
        end else begin
            imem_addr_d = imem_addr_q;
        end

        imem_req_d    = (state_d == S_REQ);
        inst_valid_d  = (state_d == S_HOLD);
        fetch_fault_d = fetch_fault_q | (state_d == S_FAULT);
    end

    // Datapath and registered output flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q          <= RESET_PC;
            pc_plus4_q    <= RESET_PC + INST_BYTES;
            inst_q        <= NOP_INST;
            inst_valid_q  <= 1'b0;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= RESET_PC;
            fetch_fault_q <= 1'b0;
            outstanding_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            pc_plus4_q    <= pc_plus4_d;
            inst_q        <= inst_d;
            inst_valid_q  <= inst_valid_d;
            imem_req_q    <= imem_req_d;
            imem_addr_q   <= imem_addr_d;
            fetch_fault_q <= fetch_fault_d;
            outstanding_q <= outstanding_d;
        end
    end

    // Port connections.
    always_comb begin
        imem_req    = imem_req_q;
        imem_addr   = imem_addr_q;
        Inst        = inst_q;
        PC          = pc_q;
        PCPlus4     = pc_plus4_q;
        inst_valid  = inst_valid_q;
        fetch_fault = fetch_fault_q;
    end

endmodule
